fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the next-generation WISC core. It replaces the single-cycle PC/IMEM path with a decoupled fetch stage: a PC sequencer issues one request at a time to a variable-latency instruction memory and buffers returned words with their PCs in a DEPTH-entry queue. Downstream, decode pulls instructions through a valid/stall handshake. Execute can redirect fetch on taken B/BR, which flushes the queue. Fetch stops on HLT.

## Interface
- WIDTH, 16: instruction and address width.
- DEPTH, 4: queue entries; power of 2, at least 2.
- RESET_PC, 16'h0000: fetch address after reset.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset. Also resets the instruction memory.
- imem_req  out  1  one-cycle fetch request; memory samples imem_addr on the same edge.
- imem_addr  out  WIDTH  fetch address. Equals fetch_pc.
- imem_rdata  in  WIDTH  returned instruction word. Valid with imem_valid.
- imem_valid  in  1  response strobe. Arrives at least 1 cycle after imem_req, exactly once per request.
- redirect  in  1  taken branch from execute; flushes all fetched state.
- redirect_pc  in  WIDTH  new fetch address, sampled when redirect=1.
- stall  in  1  decode cannot accept this cycle.
- inst  out  WIDTH  queue-head instruction.
- inst_pc  out  WIDTH  PC of the queue-head instruction.
- inst_valid  out  1  head is valid. Forced to 0 in any cycle with redirect=1.
- hlt  out  1  a HLT instruction (opcode 4'hF) is at the queue head.

## Operation
- Dequeue condition: inst_valid & ~stall & ~hlt. The HLT entry is never dequeued; it stays presented.
- imem_req = (state==FETCH) & ~redirect & (count<DEPTH). Only one request is outstanding at a time, so a returning response always has queue space.
- Enqueue entry: {fetch_pc, imem_rdata}. After enqueue, fetch_pc increments by 2 modulo 2^WIDTH (0xFFFE wraps to 0x0000).
- State FETCH:
  - redirect: fetch_pc<=redirect_pc; stay in FETCH.
  - else if imem_req: go to WAIT.
- State WAIT:
  - redirect & imem_valid: discard the word; fetch_pc<=redirect_pc; go to FETCH.
  - redirect & ~imem_valid: fetch_pc<=redirect_pc; go to DROP.
  - imem_valid: enqueue the word. If imem_rdata[15:12]==4'hF, go to HALT; otherwise go to FETCH.
- State DROP:
  - imem_valid: discard the word; go to FETCH. A redirect in the same cycle still updates fetch_pc.
  - redirect alone: update fetch_pc; stay in DROP.
- State HALT:
  - No requests are issued.
  - redirect: fetch_pc<=redirect_pc; go to FETCH. A branch older than the HLT cancels it.
- Any redirect empties the queue (count<=0, pointers<=0) in the same edge. This takes priority over a simultaneous enqueue or dequeue.
- Simultaneous enqueue and dequeue: count is unchanged, both pointers advance. Pointers wrap modulo DEPTH.

## Timing
- Reset values, applied asynchronously: state=FETCH, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, inst_valid=0, hlt=0, inst/inst_pc=0.
- First imem_req occurs in the first cycle after rst_n rises.
- Memory latency L (response on the L-th edge after the request): the word is visible on inst the cycle after that edge.
- Sustained throughput is 1 instruction per L+1 cycles: one FETCH cycle plus L WAIT cycles.
- inst_valid and hlt are registered-state functions except for the redirect mask, which is combinational.
- Reset asserted mid-WAIT drops the request. The memory is reset by the same rst_n, so no stale response can arrive.

## Structure
- Shared package `wisc_pkg`:
  - OP_HLT = 4'hF
  - fetch state enum {FETCH, WAIT, DROP, HALT}
  - PC_INC = 2
- Sub-module `fetch_queue`: parametrised circular FIFO (WIDTH, DEPTH).
  - Stores {pc, inst} pairs.
  - Ports: push, pop, flush, full, empty, head outputs.
  - count width is $clog2(DEPTH)+1.
- `fetch_unit` contains the state machine, fetch_pc register and output masking.

## Test plan
- Reset, memory with L=2 returning 0x1111/0x2222/0x3333 at 0x0000/0x0002/0x0004, stall=0 -> inst_pc 0x0000, 0x0002, 0x0004 with matching inst, one every 3 cycles.
- DEPTH=4, stall held high -> exactly 4 requests (0x0000–0x0006), then imem_req=0 and inst_valid=1 holding 0x0000. Drop stall -> next request is to 0x0008.
- Redirect to 0x0040 while WAIT with 2 entries queued -> count=0, inst_valid=0 that cycle, late response discarded, next imem_addr=0x0040.
- Redirect in the same cycle as imem_valid -> no enqueue, state FETCH, next request to redirect_pc.
- Word 0xF000 returned at 0x0006 -> no further imem_req. hlt=1 once it reaches the head, inst held while stall=0. Redirect to 0x0010 -> hlt=0, fetch resumes at 0x0010.
- fetch_pc=0xFFFE -> next request to 0x0000. rst_n pulsed low mid-WAIT -> all outputs at reset values immediately, first request to RESET_PC after release.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC fetch front end.
// Holds the HLT opcode, PC step and fetch state encoding.
package wisc_pkg;

    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int         PC_INC = 2;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP,
        HALT
    } fetch_state_t;

    function automatic logic is_hlt(input logic [3:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, inst} pairs between fetch and decode.
// A flush empties it in one edge and wins over push/pop.
module fetch_queue
    import wisc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_inst,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_inst
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]   <= push_pc;
                inst_mem[wr_ptr] <= push_inst;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: one outstanding memory request,
// queued results, branch redirect flush and stop on HLT.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_valid,
    output logic             hlt
);

    fetch_state_t     state;
    fetch_state_t     next_state;
    logic [WIDTH-1:0] fetch_pc;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic             rdata_hlt;

    fetch_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_push),
        .pop      (q_pop),
        .flush    (redirect),
        .push_pc  (fetch_pc),
        .push_inst(imem_rdata),
        .full     (q_full),
        .empty    (q_empty),
        .head_pc  (inst_pc),
        .head_inst(inst)
    );

    assign rdata_hlt  = is_hlt(imem_rdata[WIDTH-1 -: 4]);
    assign imem_addr  = fetch_pc;
    assign imem_req   = rst_n & (state == FETCH) & ~redirect & ~q_full;
    assign q_push     = (state == WAIT) & imem_valid & ~redirect;
    assign inst_valid = ~q_empty & ~redirect;
    assign hlt        = inst_valid & is_hlt(inst[WIDTH-1 -: 4]);
    assign q_pop      = inst_valid & ~stall & ~hlt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a response during DROP belongs to a cancelled path.
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH: begin
                if (imem_req) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    next_state = imem_valid ? FETCH : DROP;
                end else if (imem_valid) begin
                    next_state = rdata_hlt ? HALT : FETCH;
                end
            end
            DROP: begin
                if (imem_valid) begin
                    next_state = FETCH;
                end
            end
            HALT: begin
                if (redirect) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // Fetch address: redirect wins, otherwise step past each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (q_push) begin
            fetch_pc <= fetch_pc + WIDTH'(PC_INC);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit.
// Memory and expected queue contents are modelled at transaction level.
module tb_fetch_unit;

    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        hlt;

    fetch_unit #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .hlt        (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t      mq[$];
    logic [15:0] mem [0:32767];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_pc;
    bit          halted;
    bit          mem_busy;
    bit          stale;
    int          mem_left;
    logic [15:0] mem_addr;
    bit          mon_en = 1'b0;
    int          stall_pct;
    int          redir_pct;
    int          lat_min;
    int          lat_max;
    bit          force_redir;
    logic [15:0] force_pc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pick_pc();
        logic [15:0] r;
        case ($urandom_range(3))
            0:       r = 16'h0040;
            1:       r = 16'hFFFC;
            2:       r = 16'hFFFE;
            default: r = 16'($urandom) & 16'hFFFE;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        model_pc = RESET_PC;
        halted   = 1'b0;
        mem_busy = 1'b0;
        stale    = 1'b0;
        mem_left = 0;
        mem_addr = '0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n      = 1'b0;
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_valid = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_hlt", hlt, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        model_reset();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    // One clock of stimulus, memory response and model update.
    task automatic cycle();
        bit          req_seen;
        logic [15:0] req_addr;
        bit          exp_req;
        entry_t      e;
        @(negedge clk);
        rst_n       = 1'b1;
        stall       = ($urandom_range(99) < stall_pct);
        redirect    = ($urandom_range(99) < redir_pct) || force_redir;
        redirect_pc = force_redir ? force_pc : pick_pc();
        force_redir = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 16'($urandom);
        if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[mem_addr[15:1]];
            end
        end
        #1;
        exp_req = !mem_busy && !halted && (mq.size() < DEPTH) && !redirect;
        check("imem_req", imem_req, exp_req);
        if (exp_req && imem_req) check("imem_addr", imem_addr, model_pc);
        req_seen = imem_req;
        req_addr = imem_addr;
        #2;
        if (redirect) begin
            mq.delete();
            model_pc = redirect_pc;
            halted   = 1'b0;
            if (mem_busy && !imem_valid) stale = 1'b1;
        end else if (imem_valid && !stale) begin
            e.pc   = mem_addr;
            e.word = imem_rdata;
            mq.push_back(e);
            model_pc = mem_addr + 16'd2;
            if (imem_rdata[15:12] == 4'hF) halted = 1'b1;
        end
        if (imem_valid) begin
            mem_busy = 1'b0;
            stale    = 1'b0;
        end
        if (req_seen) begin
            mem_busy = 1'b1;
            mem_left = $urandom_range(lat_max, lat_min);
            mem_addr = req_addr;
        end
    endtask

    // Monitor: compare the presented head with the scoreboard front.
    initial begin
        forever begin
            bit exp_v;
            bit exp_h;
            @(negedge clk);
            #2;
            if (mon_en) begin
                exp_v = (mq.size() > 0) && !redirect;
                check("inst_valid", inst_valid, exp_v);
                if (exp_v) begin
                    exp_h = (mq[0].word[15:12] == 4'hF);
                    check("inst", inst, mq[0].word);
                    check("inst_pc", inst_pc, mq[0].pc);
                    check("hlt", hlt, exp_h);
                    if (!stall && !exp_h) void'(mq.pop_front());
                end else begin
                    check("hlt_idle", hlt, 0);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [15:0] w;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(7) != 0) w[15:12] = 4'hE;
            mem[i] = w;
        end
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'hF000;
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        force_redir = 1'b0;
        force_pc    = '0;
        model_reset();
        do_reset();

        lat_min = 2; lat_max = 2; stall_pct = 0; redir_pct = 0;
        repeat (30) cycle();
        check("halted_at_0006", {15'd0, halted}, 1);

        force_redir = 1'b1; force_pc = 16'h0100; stall_pct = 100;
        repeat (30) cycle();
        check("fill_depth", mq.size(), DEPTH);
        stall_pct = 0;
        repeat (20) cycle();

        force_redir = 1'b1; force_pc = 16'hFFFE;
        repeat (10) cycle();

        lat_min = 1; lat_max = 4; stall_pct = 30; redir_pct = 5;
        repeat (2000) cycle();

        guard = 0;
        while (!mem_busy && guard < 50) begin
            cycle();
            guard++;
        end
        check("reach_wait", {15'd0, mem_busy}, 1);
        do_reset();
        repeat (200) cycle();

        stall_pct = 80; redir_pct = 10;
        repeat (1500) cycle();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
